// File: rtl/serial_cmp_ctrl_if.sv
// Bundle between the serial comparator sequencer and its surroundings:
// the start/done request side plus the 2-bit comparator slice side.
// The slave modport is the sequencer; the master modport is whoever
// issues requests and hosts the comparator slice.
interface serial_cmp_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             gt;
  logic             eq;
  logic             lt;
  logic             err;
  logic [1:0]       cmp_a;
  logic [1:0]       cmp_b;
  logic             cmp_eq;
  logic             cmp_gt;
  logic             cmp_lt;

  modport master (
    output start, a, b, cmp_eq, cmp_gt, cmp_lt,
    input  busy, done, gt, eq, lt, err, cmp_a, cmp_b
  );

  modport slave (
    input  start, a, b, cmp_eq, cmp_gt, cmp_lt,
    output busy, done, gt, eq, lt, err, cmp_a, cmp_b
  );
endinterface

// File: rtl/serial_cmp_ctrl.sv
// Serial magnitude comparator sequencer.
// Walks a shared 2-bit comparator slice across two WIDTH-bit operands,
// most significant pair first, and stops at the first unequal pair.
// Optional feature macro: CMP_CHECK_EN -- when defined, the slice flags
// must be one-hot in every RUN cycle, otherwise err is raised and the
// compare terminates with gt/eq/lt all clear. When undefined, err is
// tied low and flags decode with priority gt, lt, then eq (no flag = eq).
// The interface instance must be built with the same WIDTH.
module serial_cmp_ctrl #(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst_n,
  serial_cmp_ctrl_if.slave bus
);

  localparam int P  = WIDTH / 2;
  localparam int IW = (P > 1) ? $clog2(P) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           stateQ, stateD;
  logic [IW-1:0]    idxQ, idxD;
  logic [WIDTH-1:0] aQ, aD;
  logic [WIDTH-1:0] bQ, bD;
  logic             gtQ, gtD;
  logic             eqQ, eqD;
  logic             ltQ, ltD;
  logic             pairMatch;
  logic [1:0]       pairA;
  logic [1:0]       pairB;
`ifdef CMP_CHECK_EN
  logic             errQ, errD;
  logic             flagsOneHot;
`endif

  assign pairA = aQ[{idxQ, 1'b0} +: 2];
  assign pairB = bQ[{idxQ, 1'b0} +: 2];

  // A pair counts as matching on eq, or when the slice raises no flag at all
  assign pairMatch = bus.cmp_eq | ~(bus.cmp_gt | bus.cmp_lt);

`ifdef CMP_CHECK_EN
  assign flagsOneHot = $onehot({bus.cmp_eq, bus.cmp_gt, bus.cmp_lt});
`endif

  // State and datapath registers; reset aborts and discards everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ <= IDLE;
      idxQ   <= '0;
      aQ     <= '0;
      bQ     <= '0;
      gtQ    <= 1'b0;
      eqQ    <= 1'b0;
      ltQ    <= 1'b0;
`ifdef CMP_CHECK_EN
      errQ   <= 1'b0;
`endif
    end else begin
      stateQ <= stateD;
      idxQ   <= idxD;
      aQ     <= aD;
      bQ     <= bD;
      gtQ    <= gtD;
      eqQ    <= eqD;
      ltQ    <= ltD;
`ifdef CMP_CHECK_EN
      errQ   <= errD;
`endif
    end
  end

  // Next state: accept start in IDLE, decode slice flags in RUN, drop back from DONE
  always_comb begin
    stateD = stateQ;
    idxD   = idxQ;
    aD     = aQ;
    bD     = bQ;
    gtD    = gtQ;
    eqD    = eqQ;
    ltD    = ltQ;
`ifdef CMP_CHECK_EN
    errD   = errQ;
`endif
    case (stateQ)
      IDLE: begin
        if (bus.start) begin
          stateD = RUN;
          aD     = bus.a;
          bD     = bus.b;
          idxD   = IW'(P - 1);
          gtD    = 1'b0;
          eqD    = 1'b0;
          ltD    = 1'b0;
`ifdef CMP_CHECK_EN
          errD   = 1'b0;
`endif
        end
      end
      RUN: begin
`ifdef CMP_CHECK_EN
        if (!flagsOneHot) begin
          errD   = 1'b1;
          stateD = DONE;
        end else
`endif
        if (bus.cmp_gt) begin
          gtD    = 1'b1;
          stateD = DONE;
        end else if (bus.cmp_lt) begin
          ltD    = 1'b1;
          stateD = DONE;
        end else if (pairMatch) begin
          if (idxQ == '0) begin
            eqD    = 1'b1;
            stateD = DONE;
          end else begin
            idxD = idxQ - IW'(1);
          end
        end
      end
      DONE: begin
        stateD = IDLE;
      end
      default: begin
        stateD = IDLE;
      end
    endcase
  end

  // Outputs: status from the state, slice operands only while running
  always_comb begin
    bus.busy  = (stateQ != IDLE);
    bus.done  = (stateQ == DONE);
    bus.cmp_a = (stateQ == RUN) ? pairA : 2'b00;
    bus.cmp_b = (stateQ == RUN) ? pairB : 2'b00;
    bus.gt    = gtQ;
    bus.eq    = eqQ;
    bus.lt    = ltQ;
`ifdef CMP_CHECK_EN
    bus.err   = errQ;
`else
    bus.err   = 1'b0;
`endif
  end

endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// Testbench for serial_cmp_ctrl. Hosts a behavioural 2-bit comparator
// slice (with a fault-injection input that raises gt and lt together), keeps a
// scoreboard of expected results and checks latency and flags per compare.
module tb_serial_cmp_ctrl;

  localparam int WIDTH = 8;
  localparam int P     = WIDTH / 2;

  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
    logic err;
    int   lat;
  } expT;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic faultEn = 1'b0;

  int checks   = 0;
  int failures = 0;
  expT sbQ[$];

  serial_cmp_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_cmp_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, 10 time units per cycle
  always #5 clk = ~clk;

  // Comparator slice model, optionally forced into an illegal flag pattern
  assign bus.cmp_gt = faultEn | (bus.cmp_a > bus.cmp_b);
  assign bus.cmp_lt = faultEn | (bus.cmp_a < bus.cmp_b);
  assign bus.cmp_eq = ~faultEn & (bus.cmp_a == bus.cmp_b);

  // Reference result: integer magnitude compare, latency from first differing pair
  function automatic expT modelCompare(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    expT e;
    e.gt  = (a > b);
    e.eq  = (a == b);
    e.lt  = (a < b);
    e.err = 1'b0;
    e.lat = P + 1;
    for (int p = P - 1; p >= 0; p--) begin
      if (a[2*p +: 2] != b[2*p +: 2]) begin
        e.lat = (P - p) + 1;
        break;
      end
    end
    return e;
  endfunction

  // Issues one start (called just after a falling edge), pushes the expectation
  // and waits for done; reports the done cycle, result flags and busy dropouts
  task automatic driveCompare(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              input expT exp, input bit pulseExtra,
                              output int doneCyc, output logic [3:0] flags,
                              output int busyBad);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    sbQ.push_back(exp);
    doneCyc = -1;
    flags   = '0;
    busyBad = 0;
    for (int c = 1; c <= P + 4; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.start = 1'b0;
        bus.a     = WIDTH'($urandom);
        bus.b     = WIDTH'($urandom);
      end
      if (bus.busy !== 1'b1) busyBad++;
      if (bus.done === 1'b1) begin
        doneCyc = c;
        flags   = {bus.gt, bus.eq, bus.lt, bus.err};
        break;
      end
      if (pulseExtra) begin
        bus.start = (c == 2) || (c == 3);
        bus.a     = 8'hFF;
        bus.b     = 8'h00;
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    #2;
    checks++;
    if ({bus.busy, bus.done, bus.gt, bus.eq, bus.lt, bus.err, bus.cmp_a, bus.cmp_b} !== 10'b0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got %b expected 0",
               {bus.busy, bus.done, bus.gt, bus.eq, bus.lt, bus.err, bus.cmp_a, bus.cmp_b});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL idle_after_reset: busy/done got %b expected 00", {bus.busy, bus.done});
    end
  endtask

  task automatic test_compare(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int doneCyc, busyBad;
    logic [3:0] flags;
    expT exp;
    driveCompare(a, b, modelCompare(a, b), 1'b0, doneCyc, flags, busyBad);
    exp = sbQ.pop_front();
    checks++;
    if (doneCyc !== exp.lat) begin
      failures++;
      $display("[TB] FAIL %s_latency: got %0d expected %0d", name, doneCyc, exp.lat);
    end
    checks++;
    if (flags !== {exp.gt, exp.eq, exp.lt, exp.err}) begin
      failures++;
      $display("[TB] FAIL %s_flags: got %b expected %b", name, flags, {exp.gt, exp.eq, exp.lt, exp.err});
    end
    checks++;
    if (busyBad !== 0) begin
      failures++;
      $display("[TB] FAIL %s_busy: low in %0d run cycles, expected 0", name, busyBad);
    end
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.cmp_a, bus.cmp_b} !== 6'b0) begin
      failures++;
      $display("[TB] FAIL %s_idle: busy/done/cmp got %b expected 0", name,
               {bus.busy, bus.done, bus.cmp_a, bus.cmp_b});
    end
  endtask

  task automatic test_result_hold;
    test_compare("top_pair", 8'hC0, 8'h40);
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.gt, bus.eq, bus.lt} !== 3'b100) begin
      failures++;
      $display("[TB] FAIL result_hold: got %b expected 100", {bus.gt, bus.eq, bus.lt});
    end
  endtask

  task automatic test_back_to_back;
    int doneCyc, busyBad;
    logic [3:0] flags;
    expT exp;
    driveCompare(8'h00, 8'h00, modelCompare(8'h00, 8'h00), 1'b1, doneCyc, flags, busyBad);
    exp = sbQ.pop_front();
    checks++;
    if (doneCyc !== 5 || exp.lat !== 5) begin
      failures++;
      $display("[TB] FAIL ignored_start_latency: got %0d expected 5", doneCyc);
    end
    checks++;
    if (flags !== 4'b0100) begin
      failures++;
      $display("[TB] FAIL ignored_start_flags: got %b expected 0100", flags);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL back_to_back_idle: busy got %b expected 0", bus.busy);
    end
    driveCompare(8'h5A, 8'h3C, modelCompare(8'h5A, 8'h3C), 1'b0, doneCyc, flags, busyBad);
    exp = sbQ.pop_front();
    checks++;
    if (doneCyc !== exp.lat || flags !== {exp.gt, exp.eq, exp.lt, exp.err}) begin
      failures++;
      $display("[TB] FAIL back_to_back_next: got cyc=%0d flags=%b expected cyc=%0d flags=%b",
               doneCyc, flags, exp.lat, {exp.gt, exp.eq, exp.lt, exp.err});
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int doneSeen = 0;
    bus.start = 1'b1;
    bus.a     = 8'hFF;
    bus.b     = 8'hFE;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_mid_busy_before: got %b expected 1", bus.busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.gt, bus.eq, bus.lt, bus.err, bus.cmp_a, bus.cmp_b} !== 10'b0) begin
      failures++;
      $display("[TB] FAIL reset_mid_outputs: got %b expected 0",
               {bus.busy, bus.done, bus.gt, bus.eq, bus.lt, bus.err, bus.cmp_a, bus.cmp_b});
    end
    repeat (2) begin
      @(negedge clk);
      if (bus.done !== 1'b0) doneSeen++;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) doneSeen++;
    end
    checks++;
    if (doneSeen !== 0) begin
      failures++;
      $display("[TB] FAIL reset_mid_no_done: activity in %0d cycles expected 0", doneSeen);
    end
    test_compare("after_reset", 8'hFF, 8'hFE);
  endtask

  task automatic test_fault;
    int doneCyc, busyBad;
    logic [3:0] flags;
    expT exp, fexp;
    fexp.lat = 2;
`ifdef CMP_CHECK_EN
    fexp.gt = 1'b0; fexp.eq = 1'b0; fexp.lt = 1'b0; fexp.err = 1'b1;
`else
    fexp.gt = 1'b1; fexp.eq = 1'b0; fexp.lt = 1'b0; fexp.err = 1'b0;
`endif
    faultEn = 1'b1;
    driveCompare(8'h33, 8'h33, fexp, 1'b0, doneCyc, flags, busyBad);
    faultEn = 1'b0;
    exp = sbQ.pop_front();
    checks++;
    if (doneCyc !== exp.lat) begin
      failures++;
      $display("[TB] FAIL fault_latency: got %0d expected %0d", doneCyc, exp.lat);
    end
    checks++;
    if (flags !== {exp.gt, exp.eq, exp.lt, exp.err}) begin
      failures++;
      $display("[TB] FAIL fault_flags: got %b expected %b", flags, {exp.gt, exp.eq, exp.lt, exp.err});
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    logic [WIDTH-1:0] ra, rb;
    for (int i = 0; i < 8; i++) begin
      ra = WIDTH'($urandom);
      rb = (i % 3 == 0) ? ra : WIDTH'($urandom);
      if (i % 3 == 1) rb = ra ^ WIDTH'(1 << $urandom_range(WIDTH - 1, 0));
      test_compare("random", ra, rb);
    end
  endtask

  // Scenario sequence
  initial begin
    test_reset();
    test_compare("equal", 8'hA5, 8'hA5);
    test_result_hold();
    test_compare("last_pair", 8'h12, 8'h13);
    test_back_to_back();
    test_reset_mid();
    test_fault();
    test_random();
    checks++;
    if (sbQ.size() !== 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain: %0d left expected 0", sbQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
